// File: rtl/instr_fifo.sv
// Circular queue of fetch bundles between fetch and decode, with an empty-queue bypass into the registered output.
// Output is loaded one cycle after a pop; enqueues while full are dropped.
module instr_fifo #(
  parameter int DEPTH       = 4,
  parameter int WIDTH       = 4,
  parameter int INSTR_W     = 32,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_flush,
  input  logic                            i_enqueue,
  input  logic [WIDTH-1:0][INSTR_W-1:0]   i_instrs,
  input  logic                            i_dequeue,
  output logic [WIDTH-1:0][INSTR_W-1:0]   o_instrs,
  output logic                            o_valid,
  output logic                            o_can_enqueue,
  output logic                            o_can_dequeue,
  output logic [$clog2(DEPTH+1)-1:0]      o_count,
  output logic                            o_almost_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [WIDTH-1:0][INSTR_W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          enq_ok, deq_ok, bypass;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign o_count       = count;
  assign o_can_enqueue = count < DEPTH_C;
  assign o_can_dequeue = (count != '0) | i_enqueue;
  assign o_almost_full = count >= AFULL_C;

  assign enq_ok = i_enqueue & o_can_enqueue;
  assign deq_ok = i_dequeue & o_can_dequeue;
  assign bypass = deq_ok & (count == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      o_instrs <= '0;
      o_valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      o_instrs <= '0;
      o_valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      o_valid <= deq_ok;
      if (bypass) begin
        o_instrs <= i_instrs;
      end else begin
        if (deq_ok) begin
          o_instrs <= mem[head];
          head     <= ptr_inc(head);
        end
        if (enq_ok) begin
          mem[tail] <= i_instrs;
          tail      <= ptr_inc(tail);
        end
        if (enq_ok && !deq_ok)      count <= count + 1'b1;
        else if (deq_ok && !enq_ok) count <= count - 1'b1;
      end
    end
  end
endmodule
